// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG harvester slice.
package trng_pkg;

  localparam int unsigned TRNG_W = 32;
  localparam logic [TRNG_W-1:0] ALL0 = '0;
  localparam logic [TRNG_W-1:0] ALL1 = '1;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT,
    CAPT,
    CHECK
  } harvest_state_e;

  // A word counts toward the repetition run if it repeats, or is stuck-at-0/1.
  function automatic logic is_rep_word(input logic [TRNG_W-1:0] word,
                                       input logic [TRNG_W-1:0] last);
    return (word == last) || (word == ALL0) || (word == ALL1);
  endfunction

endpackage

// File: rtl/trng_word_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
module trng_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rptr];
  assign o_valid = !w_empty;
  assign o_level = r_level;

endmodule

// File: rtl/trng_harvester.sv
// Reader side of the ring-oscillator TRNG sampler: request, capture, health-screen
// and buffer 32-bit words for a valid/ready consumer.
module trng_harvester
  import trng_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned WARMUP      = 4,
  parameter int unsigned REP_LIMIT   = 3,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          flush,
  input  logic                          fail_clr,
  output logic                          trng_en,
  output logic                          trng_trig,
  output logic                          trng_clear,
  input  logic [TRNG_W-1:0]             trng_data,
  input  logic [TRNG_W-1:0]             trng_count,
  output logic [TRNG_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          health_fail,
  output logic                          timeout_err
);

  localparam int unsigned LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WUW = $clog2(WARMUP + 2);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RW  = $clog2(REP_LIMIT + 1);

  harvest_state_e    r_state;
  logic              r_tcnt;
  logic [TRNG_W-1:0] r_snap;
  logic [TRNG_W-1:0] r_word;
  logic [TRNG_W-1:0] r_last;
  logic [WUW-1:0]    r_warm;
  logic [TW-1:0]     r_timer;
  logic [RW-1:0]     r_rep;
  logic              r_trig;
  logic              r_clear;
  logic              r_hfail;
  logic              r_tout;
  logic              r_en_d;

  logic [RW-1:0]     w_rep_next;
  logic              w_trip;
  logic              w_push;
  logic [LW-1:0]     w_level;

  assign w_rep_next = is_rep_word(r_word, r_last) ? r_rep + RW'(1) : RW'(1);
  assign w_trip     = (w_rep_next >= RW'(REP_LIMIT));
  assign w_push     = (r_state == CHECK) && enable && !flush && (r_warm == '0) && !w_trip;

  trng_word_fifo #(
    .WIDTH (TRNG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (r_word),
    .i_pop   (rd_ready),
    .o_data  (rd_data),
    .o_valid (rd_valid),
    .o_level (w_level)
  );

  // fail_clr is applied first so a simultaneous trip or timeout below overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tcnt  <= 1'b0;
      r_snap  <= '0;
      r_word  <= '0;
      r_last  <= '0;
      r_warm  <= WUW'(WARMUP);
      r_timer <= '0;
      r_rep   <= '0;
      r_trig  <= 1'b0;
      r_clear <= 1'b0;
      r_hfail <= 1'b0;
      r_tout  <= 1'b0;
      r_en_d  <= 1'b0;
    end else begin
      r_en_d  <= enable;
      r_clear <= flush;
      if (fail_clr) begin
        r_hfail <= 1'b0;
        r_tout  <= 1'b0;
        r_rep   <= '0;
      end
      if (flush) begin
        r_state <= IDLE;
        r_trig  <= 1'b0;
        r_warm  <= WUW'(WARMUP);
        r_rep   <= '0;
      end else if (!enable) begin
        r_state <= IDLE;
        r_trig  <= 1'b0;
      end else begin
        if (!r_en_d) r_warm <= WUW'(WARMUP);
        case (r_state)
          IDLE: begin
            if ((w_level < LW'(FIFO_DEPTH)) && !r_hfail) begin
              r_state <= TRIG;
              r_snap  <= trng_count;
              r_trig  <= 1'b1;
              r_tcnt  <= 1'b0;
            end
          end
          TRIG: begin
            if (r_tcnt) begin
              r_trig  <= 1'b0;
              r_timer <= '0;
              r_state <= WAIT;
            end else begin
              r_tcnt <= 1'b1;
            end
          end
          WAIT: begin
            if (trng_count != r_snap) begin
              r_state <= CAPT;
            end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
              r_tout  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
          CAPT: begin
            r_word  <= trng_data;
            r_state <= CHECK;
          end
          CHECK: begin
            if (r_warm != '0) begin
              r_warm <= r_warm - WUW'(1);
            end else begin
              r_last <= r_word;
              r_rep  <= w_rep_next;
              if (w_trip) r_hfail <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign trng_en     = enable;
  assign trng_trig   = r_trig;
  assign trng_clear  = r_clear;
  assign fifo_level  = w_level;
  assign health_fail = r_hfail;
  assign timeout_err = r_tout;

endmodule
